// File: rtl/wait_state_memory_if.sv
// Request/response bundle for wait_state_memory: the processor side is master and
// the memory is slave.
interface wait_state_memory_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  ren;
    logic                  wen;
    logic [31:0]           addr;
    logic [DATA_W-1:0]     din;
    logic [DATA_W/8-1:0]   be;
    logic                  clr_err;
    logic                  ready;
    logic                  done;
    logic [DATA_W-1:0]     dout;
    logic [1:0]            err;

    modport master (
        output ren, wen, addr, din, be, clr_err,
        input  ready, done, dout, err
    );

    modport slave (
        input  ren, wen, addr, din, be, clr_err,
        output ready, done, dout, err
    );
endinterface

// File: rtl/wait_state_memory.sv
// Word-addressed single-port memory with a fixed programmable access latency, ready/done
// handshake, byte-lane write enables and sticky error flags.
module wait_state_memory #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 3
) (
    input logic                clock,
    input logic                reset,
    wait_state_memory_if.slave bus_io
);
    localparam int unsigned NumLanes = DATA_W / 8;
    localparam int unsigned Depth    = 2 ** ADDR_W;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("wait_state_memory: LATENCY must be in 1..15");
    end
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("wait_state_memory: DATA_W must be a nonzero multiple of 8");
    end
    if (ADDR_W < 1 || ADDR_W > 31) begin : g_bad_addr_w
        $error("wait_state_memory: ADDR_W must be in 1..31");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [NumLanes-1:0]   be_q, be_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic [1:0]            err_q, err_d;
    logic [1:0]            err_set;
    logic                  resp_entry;
    logic                  req_ok, req_conflict, addr_oob;

    logic [DATA_W-1:0]     mem_q [Depth];

    assign req_ok       = bus_io.ren ^ bus_io.wen;
    assign req_conflict = bus_io.ren & bus_io.wen;
    assign addr_oob     = |bus_io.addr[31:ADDR_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        err_set    = 2'b00;
        resp_entry = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_ok) begin
                    // Access lands LATENCY edges after acceptance: the counter runs
                    // LATENCY-1 down to 0, then one more edge enters RESP.
                    state_d    = StWait;
                    cnt_d      = 4'(LATENCY - 1);
                    idx_d      = bus_io.addr[ADDR_W-1:0];
                    wdata_d    = bus_io.din;
                    be_d       = bus_io.be;
                    we_d       = bus_io.wen;
                    err_set[1] = addr_oob;
                end else if (req_conflict) begin
                    err_set[0] = 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    resp_entry = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        dout_d = (resp_entry && !we_q) ? mem_q[idx_q] : dout_q;
        err_d  = bus_io.clr_err ? 2'b00 : (err_q | err_set);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            dout_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // Array is never reset; resp_entry is low while reset holds the FSM in IDLE.
    always_ff @(posedge clock) begin
        if (resp_entry && we_q) begin
            for (int i = 0; i < int'(NumLanes); i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus_io.ready = (state_q == StIdle);
    assign bus_io.done  = (state_q == StResp);
    assign bus_io.dout  = dout_q;
    assign bus_io.err   = err_q;
endmodule

// File: tb/tb_wait_state_memory.sv
// Directed self-checking bench for wait_state_memory (DATA_W=32, ADDR_W=10, LATENCY=3).
module tb_wait_state_memory;
    localparam int unsigned Lat = 3;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    wait_state_memory_if #(.DATA_W(32)) bus ();

    wait_state_memory #(
        .DATA_W (32),
        .ADDR_W (10),
        .LATENCY(Lat)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus_io(bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request, wait (bounded) for done, check the latency, return in IDLE.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input string tag);
        int n;
        bus.ren  = !we;
        bus.wen  = we;
        bus.addr = a;
        bus.din  = d;
        bus.be   = b;
        tick();
        bus.ren = 1'b0;
        bus.wen = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, Lat);
        tick();
        chk({tag, "_ready_after"}, {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic clear_err();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("clr_err", {30'd0, bus.err}, 32'd0);
    endtask

    initial begin
        int n_done;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        bus.ren     = 1'b0;
        bus.wen     = 1'b0;
        bus.addr    = '0;
        bus.din     = '0;
        bus.be      = '0;
        bus.clr_err = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_err", {30'd0, bus.err}, 32'd0);
        reset = 1'b1;
        tick();

        // Cycle-accurate write then read of addr 5
        bus.wen = 1'b1; bus.addr = 32'd5; bus.din = 32'hDEADBEEF; bus.be = 4'hF;
        tick();  // edge T
        bus.wen = 1'b0;
        chk("wr_ready_T", {31'd0, bus.ready}, 32'd0);
        chk("wr_done_T", {31'd0, bus.done}, 32'd0);
        tick();
        chk("wr_done_T1", {31'd0, bus.done}, 32'd0);
        tick();
        chk("wr_done_T2", {31'd0, bus.done}, 32'd0);
        tick();
        chk("wr_done_T3", {31'd0, bus.done}, 32'd1);
        chk("wr_ready_T3", {31'd0, bus.ready}, 32'd0);
        tick();
        chk("wr_done_T4", {31'd0, bus.done}, 32'd0);
        chk("wr_ready_T4", {31'd0, bus.ready}, 32'd1);
        bus.ren = 1'b1; bus.addr = 32'd5;
        tick();  // edge T+5
        bus.ren = 1'b0;
        chk("rd_ready_T5", {31'd0, bus.ready}, 32'd0);
        tick();
        tick();
        chk("rd_done_T7", {31'd0, bus.done}, 32'd0);
        tick();
        chk("rd_done_T8", {31'd0, bus.done}, 32'd1);
        chk("rd_dout_T8", bus.dout, 32'hDEADBEEF);
        tick();
        chk("rd_done_T9", {31'd0, bus.done}, 32'd0);

        // Byte lanes
        access(1'b1, 32'd7, 32'h11223344, 4'hF, "bl_init");
        access(1'b1, 32'd7, 32'hAABBCCDD, 4'b0101, "bl_partial");
        access(1'b0, 32'd7, 32'h0, 4'h0, "bl_read");
        chk("bl_dout", bus.dout, 32'h11BB33DD);

        // Conflict: rejected, err[0] sticky, memory untouched
        bus.ren = 1'b1; bus.wen = 1'b1; bus.addr = 32'd7; bus.din = 32'h0; bus.be = 4'hF;
        tick();
        bus.ren = 1'b0; bus.wen = 1'b0;
        chk("cf_err", {30'd0, bus.err}, 32'd1);
        chk("cf_ready", {31'd0, bus.ready}, 32'd1);
        chk("cf_done", {31'd0, bus.done}, 32'd0);
        tick();
        chk("cf_done2", {31'd0, bus.done}, 32'd0);
        chk("cf_err_sticky", {30'd0, bus.err}, 32'd1);
        access(1'b0, 32'd7, 32'h0, 4'h0, "cf_read");
        chk("cf_mem", bus.dout, 32'h11BB33DD);
        clear_err();
        // Clear wins over a same-edge conflict
        bus.ren = 1'b1; bus.wen = 1'b1; bus.clr_err = 1'b1;
        tick();
        bus.ren = 1'b0; bus.wen = 1'b0; bus.clr_err = 1'b0;
        chk("cf_clr_prio", {30'd0, bus.err}, 32'd0);

        // Wrap-around address
        access(1'b0, 32'h00000405, 32'h0, 4'h0, "wrap");
        chk("wrap_dout", bus.dout, 32'hDEADBEEF);
        chk("wrap_err", {30'd0, bus.err}, 32'd2);
        clear_err();

        // Busy ignore: write pulse during WAIT of a read is dropped
        access(1'b1, 32'd1, 32'h01010101, 4'hF, "bi_init1");
        access(1'b1, 32'd2, 32'h02020202, 4'hF, "bi_init2");
        bus.ren = 1'b1; bus.addr = 32'd1;
        tick();
        bus.ren = 1'b0;
        n_done = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                bus.wen = 1'b1; bus.addr = 32'd2; bus.din = 32'hFFFFFFFF; bus.be = 4'hF;
            end
            if (i == 1) bus.wen = 1'b0;
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        chk("bi_ndone", n_done, 32'd1);
        chk("bi_dout", bus.dout, 32'h01010101);
        chk("bi_err", {30'd0, bus.err}, 32'd0);
        access(1'b0, 32'd2, 32'h0, 4'h0, "bi_read2");
        chk("bi_mem2", bus.dout, 32'h02020202);

        // be=0 write completes but changes nothing
        access(1'b1, 32'd2, 32'hCAFEF00D, 4'h0, "be0_write");
        access(1'b0, 32'd2, 32'h0, 4'h0, "be0_read");
        chk("be0_mem", bus.dout, 32'h02020202);

        // Reset during WAIT of a write discards it
        access(1'b1, 32'd9, 32'h99999999, 4'hF, "rw_init");
        bus.wen = 1'b1; bus.addr = 32'd9; bus.din = 32'h12345678; bus.be = 4'hF;
        tick();
        bus.wen = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rw_ready", {31'd0, bus.ready}, 32'd1);
        chk("rw_done", {31'd0, bus.done}, 32'd0);
        chk("rw_dout", bus.dout, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        access(1'b0, 32'd9, 32'h0, 4'h0, "rw_read");
        chk("rw_mem", bus.dout, 32'h99999999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
